prog_clk_divider: RTL and testbench
===================================

PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 Parameter WIDTH, default 26: divide-count width in bits.
REQ-002 Parameter DEFAULT_DIV, default 25000000: divide value after reset, giving a 1 Hz clk_out from 50 MHz mclk.
REQ-003 mclk  input  1: sole clock; all logic on rising edge.
REQ-004 rs_n  input  1: asynchronous, active-low reset.
REQ-005 en  input  1: count enable; low freezes the counter and clk_out.
REQ-006 div_val  input  WIDTH: requested divide value (half-period of clk_out, in mclk cycles).
REQ-007 load_valid  input  1: div_val offered this cycle.
REQ-008 load_ready  output  1: block can accept div_val this cycle.
REQ-009 tick  output  1: one-mclk-cycle pulse at each terminal count.
REQ-010 clk_out  output  1: registered square wave; toggles on each tick; drives downstream flip-flop stages.
REQ-011 load_err  output  1: one-cycle pulse when a transfer carries div_val == 0.
REQ-012 running  output  1: high in RUN or RUN_PEND states.

Function
REQ-013 A transfer SHALL occur when load_valid and load_ready are both high on a rising mclk edge.
REQ-014 div_val == 0 SHALL be consumed but discarded; load_err pulses the next cycle; the active divide value is unchanged.
REQ-015 The FSM SHALL have states STOP, RUN and RUN_PEND; reset enters RUN with active divide = DEFAULT_DIV.
REQ-016 STOP: counter held at active-1, tick = 0, clk_out held; en high -> RUN on the next cycle.
REQ-017 RUN: if en, counter decrements by 1 per cycle; at 0 it reloads active-1, tick = 1 that cycle, and clk_out toggles on the same edge.
REQ-018 In RUN, en low -> STOP; the counter value is retained; resumption continues from the retained value, not from a reload.
REQ-019 In RUN, a valid nonzero transfer SHALL store div_val in the pending register and go to RUN_PEND, unless the counter is at 0 that cycle.
REQ-020 For a nonzero transfer accepted while the counter is at 0 with en high, div_val SHALL become active and be used for the reload in that same cycle; state remains RUN.
REQ-021 RUN_PEND: load_ready = 0; counting continues with the old value; at the next terminal count, pending becomes active and the reload uses the new active value -> RUN.
REQ-022 load_ready SHALL be 1 in STOP and RUN, and 0 in RUN_PEND.
REQ-023 A transfer in STOP SHALL update the active value immediately and set counter = div_val-1.
REQ-024 div_val == 1 SHALL give tick every cycle while enabled, with clk_out = mclk/2.
REQ-025 clk_out SHALL change only on terminal count, so period changes are glitch-free and the high and low phases are each full half-periods.
REQ-026 Counter arithmetic SHALL be unsigned WIDTH-bit with no wrap: reload precedes any decrement below 0.
REQ-027 tick SHALL be gated by en: a frozen counter at 0 produces no repeated ticks.

Reset
REQ-028 rs_n low SHALL immediately force: state = RUN, active = DEFAULT_DIV, pending = 0, counter = DEFAULT_DIV-1, tick = 0, clk_out = 0, load_err = 0, load_ready = 1.
REQ-029 Reset during RUN_PEND SHALL discard the pending value.
REQ-030 Deassertion SHALL be synchronous to mclk, through a 2-flop synchronizer inside the block.

Structure
REQ-031 The state encoding (STOP, RUN, RUN_PEND) and DEFAULT_DIV SHALL reside in a shared package, clkdiv_pkg.
REQ-032 One sub-module, rst_sync (2-flop reset synchronizer), SHALL be used; all other logic is flat.
REQ-033 All outputs SHALL be registered, with no combinational path from input to output except load_ready, which is decoded from the state register.

Verification
REQ-034 With WIDTH = 8 and DEFAULT_DIV = 4, release reset with en = 1 -> tick on cycles 4, 8, 12, ...; clk_out rises at 4 and falls at 8.
REQ-035 Load div_val = 2 mid-period -> load_ready goes 0; the old period completes, subsequent ticks are every 2 cycles, and load_ready returns to 1.
REQ-036 Load div_val = 0 -> load_err pulses once and the tick spacing is unchanged.
REQ-037 Drop en for 5 cycles at counter = 2 -> no tick and clk_out frozen; the first tick comes 3 cycles after en returns.
REQ-038 Assert rs_n low in RUN_PEND with clk_out = 1 -> clk_out goes 0 asynchronously; after release, the period is DEFAULT_DIV and no pending value is applied.
REQ-039 Apply a load on the terminal-count cycle with div_val = 3 -> the next tick arrives 3 cycles later and the block stays in RUN.

Source files
------------

// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_pkg
//  Purpose  : Shared definitions for the programmable clock divider: the
//             divider FSM state encoding and the power-on divide value.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

  // Divider FSM states. STOP: frozen by en. RUN: counting with the active
  // value. RUN_PEND: counting, with a new value waiting for the next
  // terminal count.
  typedef enum logic [1:0] {
    ST_STOP     = 2'd0,
    ST_RUN      = 2'd1,
    ST_RUN_PEND = 2'd2
  } clkdiv_state_e;

  // Divide value after reset: 1 Hz clk_out from a 50 MHz mclk.
  localparam int CLKDIV_DEFAULT_DIV = 25000000;

endpackage : clkdiv_pkg
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// ============================================================================
//  Module   : rst_sync
//  Purpose  : Two-flop reset synchronizer. Assertion of the active-low input
//             reset propagates to the output immediately; release is
//             delayed by two clk edges so it is synchronous to clk.
//  Ports    : clk        - clock the released reset is aligned to
//             rst_n_in   - raw asynchronous active-low reset
//             rst_n_out  - active-low reset, async assert / sync release
//  Revision : 1.0 - initial release
// ============================================================================
module rst_sync (
  input  logic clk,
  input  logic rst_n_in,
  output logic rst_n_out
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= 1'b1;
      r_sync <= r_meta;
    end
  end

  assign rst_n_out = r_sync;

endmodule : rst_sync
`default_nettype wire

// File: rtl/prog_clk_divider.sv
`default_nettype none
// ============================================================================
//  Module   : prog_clk_divider
//  Purpose  : Programmable clock divider. clk_out toggles every div mclk
//             cycles (div = active half-period). New divide values arrive
//             over a valid/ready handshake and take effect only at a terminal
//             count, so clk_out never glitches or produces a short phase.
//  Ports    : mclk        - sole clock, rising edge
//             rs_n        - asynchronous active-low reset (sync release)
//             en          - count enable; low freezes counter and clk_out
//             div_val     - requested half-period in mclk cycles
//             load_valid  - div_val offered this cycle
//             load_ready  - block can accept div_val (decoded from state)
//             tick        - one-cycle pulse at each terminal count
//             clk_out     - registered divided clock
//             load_err    - one-cycle pulse after a div_val == 0 transfer
//             running     - high in RUN or RUN_PEND
//  Revision : 1.0 - initial release
// ============================================================================
module prog_clk_divider
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic             mclk,
  input  logic             rs_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             tick,
  output logic             clk_out,
  output logic             load_err,
  output logic             running
);

  localparam logic [WIDTH-1:0] c_one          = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_reset_active = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] c_reset_count  = WIDTH'(DEFAULT_DIV - 1);

  logic             rst_n_sync;
  clkdiv_state_e    r_state;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_count;

  logic w_xfer;
  logic w_load_nz;
  logic w_load_zero;
  logic w_terminal;

  rst_sync u_rst_sync (
    .clk       (mclk),
    .rst_n_in  (rs_n),
    .rst_n_out (rst_n_sync)
  );

  // The only output not coming straight from a flop: it is a pure decode of
  // the state register, so there is still no input-to-output path.
  assign load_ready  = (r_state != ST_RUN_PEND);

  assign w_xfer      = load_valid & load_ready;
  assign w_load_nz   = w_xfer & (div_val != '0);
  assign w_load_zero = w_xfer & (div_val == '0);
  assign w_terminal  = (r_count == '0);

  always_ff @(posedge mclk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_state   <= ST_RUN;
      r_active  <= c_reset_active;
      r_pending <= '0;
      r_count   <= c_reset_count;
      tick      <= 1'b0;
      clk_out   <= 1'b0;
      load_err  <= 1'b0;
      running   <= 1'b1;
    end else begin
      tick     <= 1'b0;
      // A zero divide is consumed but otherwise ignored.
      load_err <= w_load_zero;

      case (r_state)
        ST_STOP: begin
          if (w_load_nz) begin
            // Nothing is mid-period while stopped, so apply at once.
            r_active <= div_val;
            r_count  <= div_val - c_one;
            if (en) begin
              r_state <= ST_RUN;
              running <= 1'b1;
            end
          end else if (en) begin
            // Counting resumes on the same edge that leaves STOP, so a
            // low en is a pure freeze of the retained count.
            r_state <= ST_RUN;
            running <= 1'b1;
            if (w_terminal) begin
              tick    <= 1'b1;
              clk_out <= ~clk_out;
              r_count <= r_active - c_one;
            end else begin
              r_count <= r_count - c_one;
            end
          end
        end

        ST_RUN: begin
          if (en) begin
            if (w_terminal) begin
              tick    <= 1'b1;
              clk_out <= ~clk_out;
              // A load landing on the terminal count is used for this
              // very reload; no need to park it.
              if (w_load_nz) begin
                r_active <= div_val;
                r_count  <= div_val - c_one;
              end else begin
                r_count  <= r_active - c_one;
              end
            end else begin
              r_count <= r_count - c_one;
              if (w_load_nz) begin
                r_pending <= div_val;
                r_state   <= ST_RUN_PEND;
              end
            end
          end else if (w_load_nz) begin
            // Park the value; it applies at the next terminal count once
            // en returns. RUN_PEND holds while en is low.
            r_pending <= div_val;
            r_state   <= ST_RUN_PEND;
          end else begin
            r_state <= ST_STOP;
            running <= 1'b0;
          end
        end

        ST_RUN_PEND: begin
          if (en) begin
            if (w_terminal) begin
              tick     <= 1'b1;
              clk_out  <= ~clk_out;
              r_active <= r_pending;
              r_count  <= r_pending - c_one;
              r_state  <= ST_RUN;
            end else begin
              r_count <= r_count - c_one;
            end
          end
        end

        default: begin
          r_state <= ST_RUN;
          running <= 1'b1;
        end
      endcase
    end
  end

endmodule : prog_clk_divider
`default_nettype wire

// File: tb/tb_prog_clk_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_clk_divider
//  Purpose  : Self-checking bench for prog_clk_divider (WIDTH=8,
//             DEFAULT_DIV=4). A behavioural model counts edges remaining
//             until the next terminal count; outputs are compared against it
//             every cycle, with literal expectations at key points.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_clk_divider;

  localparam int WIDTH = 8;
  localparam int DEF   = 4;

  logic             mclk = 1'b0;
  logic             rs_n;
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             load_valid;
  logic             load_ready;
  logic             tick;
  logic             clk_out;
  logic             load_err;
  logic             running;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  prog_clk_divider #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEF)
  ) dut (
    .mclk       (mclk),
    .rs_n       (rs_n),
    .en         (en),
    .div_val    (div_val),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .tick       (tick),
    .clk_out    (clk_out),
    .load_err   (load_err),
    .running    (running)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge mclk);
      #2;
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_rem = enabled edges left until the next terminal count.
  int   m_sync = 0;
  int   m_act, m_rem, m_pend;
  bit   m_pend_valid, m_stopped;
  bit   m_xfer, m_nz, m_adv;
  logic e_tick, e_clk, e_err;

  always @(posedge mclk or negedge rs_n) begin
    if (!rs_n) begin
      m_sync = 0; m_act = DEF; m_rem = DEF; m_pend = 0;
      m_pend_valid = 1'b0; m_stopped = 1'b0;
      e_tick = 1'b0; e_clk = 1'b0; e_err = 1'b0;
    end else if (m_sync < 2) begin
      m_sync++;
    end else begin
      m_xfer = load_valid && !m_pend_valid;
      m_nz   = m_xfer && (div_val != 0);
      e_err  = m_xfer && (div_val == 0);
      e_tick = 1'b0;
      m_adv  = 1'b0;
      if (m_stopped) begin
        if (m_nz) begin
          m_act = int'(div_val); m_rem = m_act; m_stopped = !en;
        end else if (en) begin
          m_stopped = 1'b0; m_adv = 1'b1;
        end
      end else if (en) begin
        m_adv = 1'b1;
      end else if (m_nz) begin
        m_pend_valid = 1'b1; m_pend = int'(div_val);
      end else if (!m_pend_valid) begin
        m_stopped = 1'b1;
      end
      if (m_adv) begin
        if (m_rem == 1) begin
          e_tick = 1'b1;
          e_clk  = !e_clk;
          if (m_pend_valid) begin
            m_act = m_pend; m_pend_valid = 1'b0;
          end else if (m_nz) begin
            m_act = int'(div_val);
          end
          m_rem = m_act;
        end else begin
          m_rem--;
          if (m_nz) begin
            m_pend_valid = 1'b1; m_pend = int'(div_val);
          end
        end
      end
    end
  end

  always @(posedge mclk) begin
    #2;
    if (cmp_en) begin
      check("model_tick",     tick,       e_tick);
      check("model_clk_out",  clk_out,    e_clk);
      check("model_load_err", load_err,   e_err);
      check("model_running",  running,    !m_stopped);
      check("model_ready",    load_ready, !m_pend_valid);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rs_n = 1'b0; en = 1'b1; load_valid = 1'b0; div_val = '0;
    step(3);
    cmp_en = 1'b1;
    step(1);
    check("rst_tick", tick, 0);
    check("rst_clk_out", clk_out, 0);
    check("rst_ready", load_ready, 1);
    check("rst_running", running, 1);
    check("rst_load_err", load_err, 0);

    // Default period 4: ticks on the 4th and 8th active edge.
    rs_n = 1'b1;
    step(2);
    step(3);
    check("def_no_tick_3", tick, 0);
    step(1);
    check("def_tick_4", tick, 1);
    check("def_clk_rise_4", clk_out, 1);
    step(4);
    check("def_tick_8", tick, 1);
    check("def_clk_fall_8", clk_out, 0);

    // Mid-period load of 2.
    step(1);
    load_valid = 1'b1; div_val = 8'd2;
    step(1);
    load_valid = 1'b0;
    check("pend_ready_low", load_ready, 0);
    step(2);
    check("pend_old_period_tick", tick, 1);
    check("pend_ready_back", load_ready, 1);
    step(1);
    check("div2_gap", tick, 0);
    step(1);
    check("div2_tick", tick, 1);

    // Zero load: error pulse, spacing unchanged.
    load_valid = 1'b1; div_val = 8'd0;
    step(1);
    load_valid = 1'b0;
    check("zero_err_pulse", load_err, 1);
    step(1);
    check("zero_tick", tick, 1);
    check("zero_err_once", load_err, 0);
    step(2);
    check("zero_spacing", tick, 1);

    // Load 5, then freeze at counter 2 for 5 cycles.
    load_valid = 1'b1; div_val = 8'd5;
    step(1);
    load_valid = 1'b0;
    check("div5_pending", load_ready, 0);
    step(1);
    check("div5_applied_tick", tick, 1);
    step(2);
    en = 1'b0;
    step(1);
    check("stop_running_low", running, 0);
    step(4);
    en = 1'b1;
    step(2);
    check("resume_no_tick", tick, 0);
    check("resume_clk_held", clk_out, 1);
    step(1);
    check("resume_tick_3", tick, 1);

    // Load 3 on the terminal-count cycle.
    step(4);
    load_valid = 1'b1; div_val = 8'd3;
    step(1);
    load_valid = 1'b0;
    check("tc_load_tick", tick, 1);
    check("tc_load_stays_run", load_ready, 1);
    step(3);
    check("tc_load_next_tick", tick, 1);

    // Divide by 1: tick every cycle.
    load_valid = 1'b1; div_val = 8'd1;
    step(1);
    load_valid = 1'b0;
    step(2);
    check("div1_tick_a", tick, 1);
    step(1);
    check("div1_tick_b", tick, 1);
    check("div1_clk_half", clk_out, 0);
    step(1);
    check("div1_tick_c", tick, 1);

    // Back to 4, then reset while RUN_PEND with clk_out high.
    load_valid = 1'b1; div_val = 8'd4;
    step(1);
    load_valid = 1'b0;
    check("div4_immediate_tick", tick, 1);
    step(4);
    check("div4_tick", tick, 1);
    check("div4_clk_high", clk_out, 1);
    load_valid = 1'b1; div_val = 8'd6;
    step(1);
    load_valid = 1'b0;
    check("rp_ready_low", load_ready, 0);
    check("rp_clk_high", clk_out, 1);
    #3;
    rs_n = 1'b0;
    #1;
    check("async_clk_low", clk_out, 0);
    check("async_ready", load_ready, 1);
    check("async_running", running, 1);
    step(2);
    rs_n = 1'b1;
    step(2);
    step(4);
    check("post_rst_tick_4", tick, 1);
    step(4);
    check("post_rst_tick_8", tick, 1);
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_prog_clk_divider
`default_nettype wire
